// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer: keypad codes, entry FSM states
// and BCD limits used by the keypad front end and the counter chain.
package timer_pkg;

   localparam logic [3:0] KEY_CLEAR    = 4'hA;
   localparam logic [3:0] KEY_START    = 4'hB;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      LOAD  = 2'd2,
      RUN   = 2'd3
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Brings the asynchronous keypad strobe into the clk domain and emits a
// single-cycle pulse on each rising edge of the synchronised level.
module key_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clrn,
   input  logic i_async,
   output logic o_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync[0] <= i_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // Level-to-pulse: a held key yields exactly one pulse.
   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad front end of the microwave timer: builds the MM:SS BCD preset,
// loads the down-counter chain and tracks the run session until zero.
module keypad_time_entry
   import timer_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_DIGITS  = 4
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       tick,
   input  logic       door_open,
   input  logic       timer_zero,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       loadn,
   output logic       cnt_en,
   output logic       running,
   output logic       err,
   output logic [2:0] digit_cnt
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_mt, r_mo, r_st, r_so;
   logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
   logic [2:0] r_cnt, w_cnt_nxt;
   logic       r_loadn, w_loadn_nxt;
   logic       r_running, w_running_nxt;
   logic       r_err, w_err_nxt;
   logic       w_key_hit, w_clear, w_start, w_digit, w_reject, w_cnt_en;

   key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_sync (
      .clk     (clk),
      .clrn    (clrn),
      .i_async (key_valid),
      .o_pulse (w_key_hit)
   );

   // key_code is stable while key_valid is high, so it is consumed directly
   // on the key_hit edge.
   assign w_clear  = w_key_hit & (key_code == KEY_CLEAR);
   assign w_start  = w_key_hit & (key_code == KEY_START);
   assign w_digit  = w_key_hit & is_digit(key_code);
   assign w_reject = ({r_mt, r_mo, r_st, r_so} == 16'h0000) |
                     (r_st > SEC_TENS_MAX) | door_open;

   always_comb begin
      w_state_nxt = r_state;
      w_mt_nxt    = r_mt;
      w_mo_nxt    = r_mo;
      w_st_nxt    = r_st;
      w_so_nxt    = r_so;
      w_cnt_nxt   = r_cnt;
      w_loadn_nxt = 1'b1;
      w_err_nxt   = 1'b0;
      w_cnt_en    = 1'b0;
      case (r_state)
         IDLE, ENTRY: begin
            if (w_clear) begin
               {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = 16'h0000;
               w_cnt_nxt   = 3'd0;
               w_state_nxt = IDLE;
            end else if (w_start) begin
               if (w_reject) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_state_nxt = LOAD;
                  w_loadn_nxt = 1'b0;
               end
            end else if (w_digit && (r_cnt < MAX_CNT)) begin
               w_mt_nxt    = r_mo;
               w_mo_nxt    = r_st;
               w_st_nxt    = r_so;
               w_so_nxt    = key_code;
               w_cnt_nxt   = r_cnt + 3'd1;
               w_state_nxt = ENTRY;
            end
         end
         LOAD: begin
            // Counters load only when enabled, so enable rides with loadn.
            w_cnt_en    = 1'b1;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (w_clear || timer_zero) begin
               {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = 16'h0000;
               w_cnt_nxt   = 3'd0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_en = tick & ~door_open;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_running_nxt = (w_state_nxt == RUN);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state   <= IDLE;
         r_mt      <= 4'd0;
         r_mo      <= 4'd0;
         r_st      <= 4'd0;
         r_so      <= 4'd0;
         r_cnt     <= 3'd0;
         r_loadn   <= 1'b1;
         r_running <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mt      <= w_mt_nxt;
         r_mo      <= w_mo_nxt;
         r_st      <= w_st_nxt;
         r_so      <= w_so_nxt;
         r_cnt     <= w_cnt_nxt;
         r_loadn   <= w_loadn_nxt;
         r_running <= w_running_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign min_tens  = r_mt;
   assign min_ones  = r_mo;
   assign sec_tens  = r_st;
   assign sec_ones  = r_so;
   assign digit_cnt = r_cnt;
   assign loadn     = r_loadn;
   assign running   = r_running;
   assign err       = r_err;
   assign cnt_en    = w_cnt_en;

endmodule
